// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the single-outstanding memory responder.
// Included by the interface, storage array and top-level responder.
package mem_resp_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH_BITS = 10;
    localparam int DEF_LATENCY    = 2;
    localparam int BYTE_LANES     = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bundle between a requester and mem_responder.
// err_o exists only when MEM_RESP_RANGE_CHECK_EN is defined.
interface mem_resp_if
    import mem_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] req_addr_i;
    logic             req_write_i;
    logic             req_byte_op_i;
    logic [WIDTH-1:0] req_wdata_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [WIDTH-1:0] resp_data_o;
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic             err_o;

    modport master (
        output req_valid_i, req_addr_i, req_write_i,
        output req_byte_op_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i,
        input  req_byte_op_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, err_o
    );
`else
    modport master (
        output req_valid_i, req_addr_i, req_write_i,
        output req_byte_op_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i,
        input  req_byte_op_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o
    );
`endif

endinterface

// File: rtl/mem_resp_array.sv
// Word storage with synchronous byte-enabled write and combinational read.
// Contents are never initialised.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [BYTE_LANES-1:0] be_i,
    input  logic [DEPTH_BITS-1:0] idx_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] wr_word_d;

    // Bits above the four byte lanes follow a full-word write only.
    always_comb begin
        mask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (b < 8 * BYTE_LANES) begin
                mask[b] = be_i[2'((b / 8) % BYTE_LANES)];
            end else begin
                mask[b] = &be_i;
            end
        end
        wr_word_d = (mem_q[idx_i] & ~mask) | (wdata_i & mask);
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wr_word_d;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed request-to-response latency.
// Define MEM_RESP_RANGE_CHECK_EN to flag out-of-range addresses on err_o.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_BITS = DEF_DEPTH_BITS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mem_resp_if.slave bus
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  byte_q, byte_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]      resp_data_q, resp_data_d;
    logic                  err_q, err_d;

    logic                  we;
    logic [BYTE_LANES-1:0] be;
    logic [WIDTH-1:0]      wr_data;
    logic [WIDTH-1:0]      rdata;
    logic [WIDTH-1:0]      rd_sel;
    logic [1:0]            lane;
    logic                  addr_err;

    assign lane = addr_q[1:0];

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign addr_err   = |addr_q[WIDTH-1:DEPTH_BITS+2];
    assign bus.err_o  = err_q;
`else
    logic unused_addr_hi;
    assign addr_err       = 1'b0;
    assign unused_addr_hi = ^{addr_q[WIDTH-1:DEPTH_BITS+2], err_q};
`endif

    assign be      = byte_q ? BYTE_LANES'(1 << lane) : '1;
    assign wr_data = byte_q ? WIDTH'({BYTE_LANES{wdata_q[7:0]}}) : wdata_q;
    assign rd_sel  = byte_q ? WIDTH'(rdata[{lane, 3'b000} +: 8]) : rdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        byte_d       = byte_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        err_d        = err_q;
        we           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    write_d = bus.req_write_i;
                    byte_d  = bus.req_byte_op_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Read data is sampled before the write lands.
                    we           = write_q & ~addr_err;
                    resp_valid_d = 1'b1;
                    resp_data_d  = (write_q | addr_err) ? '0 : rd_sel;
                    err_d        = addr_err;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    err_d        = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;

    mem_resp_array #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (we),
        .be_i    (be),
        .idx_i   (addr_q[DEPTH_BITS+1:2]),
        .wdata_i (wr_data),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random traffic against a word-array
// model, plus backpressure, mid-operation reset, range and LATENCY=1 cases.
module tb_mem_responder;

    localparam int W   = 32;
    localparam int DB  = 10;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        longint      t_acc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic bp_rand;
    logic rr_force;
    logic rr_rand;

    int nchk;
    int nfail;

    exp_t sq[$];
    exp_t q1[$];
    logic [31:0] model [int];
    logic [31:0] m1 [4];

    mem_resp_if #(.WIDTH(W)) bus ();
    mem_resp_if #(.WIDTH(W)) bus1 ();

    mem_responder #(
        .WIDTH      (W),
        .DEPTH_BITS (DB),
        .LATENCY    (LAT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    mem_responder #(
        .WIDTH      (W),
        .DEPTH_BITS (DB),
        .LATENCY    (1)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rr_rand <= ($urandom_range(0, 3) != 0);

    assign bus.resp_ready_i  = bp_rand ? rr_rand : rr_force;
    assign bus1.resp_ready_i = 1'b1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_to(string nm);
        nchk++;
        nfail++;
        $display("FAIL %s: timeout", nm);
    endtask

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << DB) - 1));
    endfunction

    function automatic logic aerr(logic [31:0] a);
`ifdef MEM_RESP_RANGE_CHECK_EN
        return (a >> (DB + 2)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: compute the response and apply the write to the model.
    function automatic exp_t model_op(logic w, logic b, logic [31:0] a,
                                      logic [31:0] wd);
        exp_t e;
        logic [31:0] t;
        int i;
        int ln;
        i  = widx(a);
        ln = int'(a[1:0]);
        e.err  = aerr(a);
        e.data = 32'h0;
        e.t_acc = 0;
        if (!e.err) begin
            if (w) begin
                if (b) begin
                    t = model[i];
                    t[8*ln +: 8] = wd[7:0];
                    model[i] = t;
                end else begin
                    model[i] = wd;
                end
            end else if (b) begin
                e.data = (model[i] >> (8 * ln)) & 32'hFF;
            end else begin
                e.data = model[i];
            end
        end
        return e;
    endfunction

    task automatic do_req(logic w, logic b, logic [31:0] a, logic [31:0] wd);
        int g;
        exp_t e;
        @(negedge clk);
        bus.req_valid_i   = 1'b1;
        bus.req_write_i   = w;
        bus.req_byte_op_i = b;
        bus.req_addr_i    = a;
        bus.req_wdata_i   = wd;
        g = 0;
        while (!bus.req_ready_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            fail_to("req_accept");
            bus.req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            e = model_op(w, b, a, wd);
            e.t_acc = longint'($time);
            sq.push_back(e);
            @(negedge clk);
            bus.req_valid_i = 1'b0;
            bus.req_addr_i  = $urandom;
            bus.req_wdata_i = $urandom;
            bus.req_write_i = $urandom_range(0, 1) != 0;
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sq.size() != 0) fail_to("drain");
    endtask

    // Main scoreboard monitor.
    initial begin
        logic        pv;
        logic [31:0] pd;
        exp_t        e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (bus.resp_valid_o) begin
                    if (sq.size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL unexpected_resp: got %h expected none",
                                 bus.resp_data_o);
                    end else begin
                        if (!pv) begin
                            chk("latency",
                                32'($time - 5 - sq[0].t_acc), 32'(LAT * 10));
                        end else begin
                            chk("hold_data", bus.resp_data_o, pd);
                        end
                        if (bus.resp_ready_i) begin
                            e = sq.pop_front();
                            chk("resp_data", bus.resp_data_o, e.data);
`ifdef MEM_RESP_RANGE_CHECK_EN
                            chk("err", 32'(bus.err_o), 32'(e.err));
`endif
                        end
                    end
                end
                pv = bus.resp_valid_o;
                pd = bus.resp_data_o;
            end
        end
    end

    // LATENCY=1 monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus1.resp_valid_o) begin
                if (q1.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL lat1_unexpected: got %h expected none",
                             bus1.resp_data_o);
                end else begin
                    chk("lat1_latency", 32'($time - 5 - q1[0].t_acc), 32'd10);
                    e = q1.pop_front();
                    chk("lat1_data", bus1.resp_data_o, e.data);
                end
            end
        end
    end

    initial begin
        int          g;
        logic [31:0] a;
        logic [31:0] d;
        longint      ta;
        longint      tp;
        exp_t        e;

        nchk     = 0;
        nfail    = 0;
        rst_n    = 1'b0;
        bp_rand  = 1'b0;
        rr_force = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_write_i    = 1'b0;
        bus.req_byte_op_i  = 1'b0;
        bus.req_wdata_i    = '0;
        bus1.req_valid_i   = 1'b0;
        bus1.req_addr_i    = '0;
        bus1.req_write_i   = 1'b0;
        bus1.req_byte_op_i = 1'b0;
        bus1.req_wdata_i   = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("rst_data", bus.resp_data_o, 32'd0);
`ifdef MEM_RESP_RANGE_CHECK_EN
        chk("rst_err", 32'(bus.err_o), 32'd0);
`endif
        rst_n = 1'b1;

        for (int k = 0; k <= 32; k++) do_req(1'b1, 1'b0, 32'(k * 4), $urandom);

        do_req(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 32'h40, 32'h0);

        do_req(1'b1, 1'b0, 32'h40, 32'h11223344);
        do_req(1'b1, 1'b1, 32'h42, 32'h5A5A5AA5);
        do_req(1'b0, 1'b0, 32'h40, 32'h0);
        do_req(1'b0, 1'b1, 32'h42, 32'h0);
        wait_drain();

        // Backpressure: response held while a second request waits.
        @(posedge clk);
        #1 rr_force = 1'b0;
        do_req(1'b0, 1'b0, 32'h40, 32'h0);
        g = 0;
        while (!bus.resp_valid_o && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (!bus.resp_valid_o) fail_to("bp_valid");
        bus.req_valid_i   = 1'b1;
        bus.req_write_i   = 1'b1;
        bus.req_byte_op_i = 1'b0;
        bus.req_addr_i    = 32'h44;
        bus.req_wdata_i   = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid_o), 32'd1);
            chk("bp_ready", 32'(bus.req_ready_o), 32'd0);
            if (sq.size() != 0) chk("bp_data", bus.resp_data_o, sq[0].data);
        end
        @(posedge clk);
        #1 rr_force = 1'b1;
        do_req(1'b1, 1'b0, 32'h44, 32'h0BADF00D);
        do_req(1'b0, 1'b0, 32'h44, 32'h0);
        wait_drain();

        // Reset while a write sits in WAIT.
        @(negedge clk);
        bus.req_valid_i   = 1'b1;
        bus.req_write_i   = 1'b1;
        bus.req_byte_op_i = 1'b0;
        bus.req_addr_i    = 32'h80;
        bus.req_wdata_i   = 32'h12345678;
        g = 0;
        while (!bus.req_ready_o && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("midrst_valid", 32'(bus.resp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 1'b0, 32'h80, 32'h0);

        do_req(1'b1, 1'b0, 32'h0, 32'h01020304);
        do_req(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D);
        do_req(1'b0, 1'b0, 32'h0, 32'h0);
        wait_drain();

        @(posedge clk);
        #1 bp_rand = 1'b1;
        repeat (150) begin
            a = 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 255) << 12);
            do_req($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, a, $urandom);
        end
        wait_drain();
        @(posedge clk);
        #1 bp_rand = 1'b0;

        // LATENCY=1, back-to-back with the requester never idle.
        tp = 0;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            @(negedge clk);
            bus1.req_valid_i   = 1'b1;
            bus1.req_write_i   = (k < 4);
            bus1.req_byte_op_i = 1'b0;
            bus1.req_addr_i    = 32'(32'h190 + (k % 4) * 4);
            bus1.req_wdata_i   = d;
            g = 0;
            while (!bus1.req_ready_o && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) begin
                fail_to("lat1_accept");
            end else begin
                @(posedge clk);
                ta = longint'($time);
                if (k > 0) chk("lat1_gap", 32'(ta - tp), 32'd30);
                tp = ta;
                e.err   = 1'b0;
                e.t_acc = ta;
                e.data  = (k < 4) ? 32'h0 : m1[k % 4];
                if (k < 4) m1[k % 4] = d;
                q1.push_back(e);
            end
        end
        @(negedge clk);
        bus1.req_valid_i = 1'b0;
        g = 0;
        while (q1.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (q1.size() != 0) fail_to("lat1_drain");

        chk("sb_empty", 32'(sq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address and data width in bits.
REQ-002 SHALL have parameter DEPTH_BITS, default 10: log2 of the number of storage words.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to response valid.
REQ-004 SHALL have port clk_i, input, width 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, width 1: asynchronous active-low reset.
REQ-006 SHALL have port req_valid_i, input, width 1: requester presents a request.
REQ-007 SHALL have port req_ready_o, output, width 1: responder can accept a request.
REQ-008 SHALL have port req_addr_i, input, width WIDTH: byte address.
REQ-009 SHALL have port req_write_i, input, width 1: 1 means write, 0 means read.
REQ-010 SHALL have port req_byte_op_i, input, width 1: 1 means a single-byte access, 0 means a word access.
REQ-011 SHALL have port req_wdata_i, input, width WIDTH: write data; the byte lane is bits [7:0].
REQ-012 SHALL have port resp_valid_o, output, width 1: response is available.
REQ-013 SHALL have port resp_ready_i, input, width 1: requester accepts the response.
REQ-014 SHALL have port resp_data_o, output, width WIDTH: read data.
REQ-015 SHALL have port err_o, output, width 1: address error, present only when MEM_RESP_RANGE_CHECK_EN is defined.

Function
REQ-016 SHALL be a three-state FSM with states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready_o high only in IDLE.
REQ-018 SHALL accept a request when req_valid_i and req_ready_o are both high on a rising edge, then latch addr, write, byte_op and wdata and enter WAIT.
REQ-019 SHALL, on acceptance, load a down-counter with LATENCY-1, decrement it each cycle in WAIT, and enter RESP when it is 0; resp_valid_o rises exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL index storage by word, index = addr[DEPTH_BITS+1:2]; without the macro, upper address bits are ignored.
REQ-021 SHALL commit a word write, all 4 bytes, on the WAIT-to-RESP edge.
REQ-022 SHALL commit a byte write to byte lane addr[1:0] only, on the WAIT-to-RESP edge, leaving the other three bytes unchanged.
REQ-023 SHALL, for a word read, return the whole stored word on resp_data_o; addr[1:0] is ignored for word accesses.
REQ-024 SHALL, for a byte read, return byte lane addr[1:0] zero-extended to WIDTH.
REQ-025 SHALL, for a write, drive resp_data_o to 0; the response still handshakes and serves as the write acknowledge.
REQ-026 SHALL hold resp_valid_o and resp_data_o stable in RESP until resp_ready_i is high, then return to IDLE on that edge.
REQ-027 SHALL ignore new requests during WAIT and RESP; the requester holds its request until req_ready_o is high.
REQ-028 SHALL leave the latched request unchanged when req_valid_i falls during WAIT.
REQ-029 SHALL, with LATENCY=1, make the response valid on the cycle after acceptance with no WAIT dwell; WAIT is entered and exited on consecutive edges.
REQ-030 SHALL not initialise storage contents; reads of never-written words return X.

Reset
REQ-031 SHALL, while rst_ni is low, force the FSM to IDLE, req_ready_o to 1, resp_valid_o to 0, resp_data_o to 0, the counter to 0 and err_o to 0.
REQ-032 SHALL, on reset during WAIT, commit no write; storage keeps its pre-request contents.
REQ-033 SHALL, on reset during RESP, drop the pending response; a write already committed on the WAIT-to-RESP edge stays committed.

Configuration
REQ-034 SHALL, when MEM_RESP_RANGE_CHECK_EN is defined, flag any request with nonzero addr[WIDTH-1:DEPTH_BITS+2] as an error: no storage write, resp_data_o=0, and err_o=1 for the whole RESP state.
REQ-035 SHALL, when MEM_RESP_RANGE_CHECK_EN is undefined, omit err_o and its logic and wrap addresses silently per REQ-020.

Structure
REQ-036 SHALL take the FSM state enum, the default WIDTH, DEPTH_BITS and LATENCY values, and the byte-lane count constant (4) from the shared package mem_resp_pkg.
REQ-037 SHALL instantiate exactly one sub-module, mem_resp_array: a synchronous-write, combinational-read storage array with a 4-bit byte-enable.

Verification
REQ-038 SHALL cover a word write then read: write 0xDEADBEEF to 0x40 with LATENCY=2, then read 0x40 -> resp_valid_o rises 2 cycles after each acceptance, and the read returns 0xDEADBEEF.
REQ-039 SHALL cover a byte write then byte read: byte write 0xA5 to 0x42 over 0x11223344 at word 0x40 -> word read returns 0x11A53344, and a byte read of 0x42 returns 0x000000A5.
REQ-040 SHALL cover response backpressure: hold resp_ready_i=0 for 5 cycles -> resp_valid_o and resp_data_o stay stable, req_ready_o stays 0, and a new req_valid_i is ignored until the handshake.
REQ-041 SHALL cover reset mid-operation: assert rst_ni low in WAIT of a write of 0x12345678 to 0x80 -> req_ready_o=1 and resp_valid_o=0 immediately, and a later read of 0x80 returns the old value.
REQ-042 SHALL cover the range check with MEM_RESP_RANGE_CHECK_EN defined and DEPTH_BITS=10: write to 0x00001000 -> err_o=1 with the response, and a read of 0x0 is unchanged; with the macro undefined, the same write lands at word 0.
REQ-043 SHALL cover LATENCY=1 back-to-back requests with resp_ready_i tied to 1 -> one response per 3 cycles, with correct data order.
